multiport_regfile: RTL and testbench
====================================

Name: multiport_regfile

Overview:
- Parametrised successor to the single-write, dual-read integer register file.
- Adds N read ports, M write ports, optional same-cycle write-to-read bypass, and a per-register busy scoreboard for pipeline hazard detection.
- Sits between decode (reads, reservations) and writeback (writes, busy clear) in the pipelined CPU.
- Takes register addresses directly; it does not decode instructions.

Parameters:
- XLEN, 32, data width in bits.
- NUM_REGS, 32, number of architectural registers (>=2).
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 1, number of write ports (1..2).
- ZERO_REG, 1, 1 = register 0 is hardwired to zero.
- BYPASS, 1, 1 = same-cycle write data and busy-clear are forwarded to read ports.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD x AW  read addresses; AW = $clog2(NUM_REGS).
- rd_data  out  NUM_RD x XLEN  read data.
- rd_busy  out  NUM_RD  1 = addressed register has a pending producer.
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR x AW  write addresses.
- wr_data  in  NUM_WR x XLEN  write data.
- rsv_en  in  1  mark rsv_addr busy (instruction issued).
- rsv_addr  in  AW  destination being reserved.
- flush  in  1  clear all busy bits (pipeline flush).
- any_busy  out  1  OR of all busy bits.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset:
  - All registers and all busy bits go to 0 immediately.
  - Therefore rd_data=0, rd_busy=0, any_busy=0 during and after reset.
  - Reset asserted mid-operation discards any write or reservation in that cycle.
- Write (rising clk):
  - For each port w with wr_en[w]=1, wr_data[w] is stored to wr_addr[w] at the edge.
  - Two ports targeting the same address: the highest-index port wins.
  - ZERO_REG=1: writes to address 0 are ignored and register 0 always reads 0.
  - Addresses >= NUM_REGS: writes are ignored.
- Read (combinational, zero latency):
  - rd_data[r] = reg[rd_addr[r]].
  - Address >= NUM_REGS reads 0.
  - ZERO_REG=1 and address 0 reads 0, never bypassed.
  - BYPASS=1: if any enabled write port targets rd_addr[r] this cycle (valid, non-zero address), rd_data[r] = that port's wr_data, highest-index match wins.
  - BYPASS=0: the old value is read; the new value is visible the next cycle.
- Scoreboard (busy[NUM_REGS], registered):
  - rsv_en=1: sets busy[rsv_addr] at the next edge.
  - Enabled write to addr: clears busy[addr] at the next edge.
  - Same-cycle reservation and write to the same address: set wins, because the new producer supersedes the old one.
  - flush=1: clears all busy bits and has priority over rsv_en in the same cycle.
  - Address 0 (ZERO_REG=1) and out-of-range addresses: never set busy.
  - rd_busy[r] = busy[rd_addr[r]].
  - BYPASS=1: rd_busy[r] is forced to 0 when a same-cycle write to that address is being forwarded.
  - any_busy = |busy, registered state only, no bypass.
- No internal state machine beyond the storage and busy arrays.
- Write-port priority is resolved with a priority encoder, not by relying on last-assignment-wins across ports.

Decomposition:
- Package rf_pkg:
  - Function rf_aw(n) returning $clog2(n).
  - Localparam defaults XLEN_DEF=32, NREG_DEF=32.
  - Typedef rf_addr_t and rf_data_t, sized from the defaults.
- Sub-module rf_scoreboard:
  - Contains the busy array, set/clear/flush priority logic, and any_busy.
  - Receives write-enable/address vectors and reservation inputs.
  - Exposes busy as a NUM_REGS vector.
- Top level keeps storage, bypass muxing and rd_busy forwarding.

Test Plan:
- Reset with rst_n low mid-write: wr_en=1, addr 5, data 0xDEAD_BEEF; rst_n falls before the edge -> reg5 reads 0, any_busy=0.
- Write addr 3 = 0x1234_5678, read rd_addr[0]=3 in the same cycle:
  - BYPASS=1 -> rd_data[0]=0x1234_5678 immediately.
  - BYPASS=0 -> 0 in that cycle, 0x1234_5678 the next cycle.
- Write addr 0 = 0xFFFF_FFFF with ZERO_REG=1 -> rd_data=0 in the same and next cycle; rsv_addr=0 leaves any_busy=0.
- NUM_WR=2, both ports write addr 7 (port0=0xAAAA, port1=0x5555) -> next-cycle read of 7 = 0x5555.
- rsv_en on addr 9, then read 9 -> rd_busy=1 one cycle later; write to 9 while reading 9 (BYPASS=1) -> rd_busy=0 and forwarded data in that cycle, busy cleared afterwards.
- Collisions:
  - rsv_en on addr 4 plus write to addr 4 in the same cycle -> busy[4]=1 afterwards.
  - flush plus rsv_en on addr 6 in the same cycle -> any_busy=0 afterwards.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared sizing helpers and default widths for the multiport register file.
package rf_pkg;

  function automatic int rf_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // An address is usable when it is inside the array and is not the hardwired zero register.
  function automatic logic rf_addr_ok(input int unsigned a, input int unsigned n, input bit zero_reg);
    return (a < n) && !(zero_reg && (a == 0));
  endfunction

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef logic [rf_aw(NREG_DEF)-1:0] rf_addr_t;
  typedef logic [XLEN_DEF-1:0]        rf_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on reservation, cleared on writeback, wiped on flush.
// State visible one cycle after the edge; no backpressure, every request is taken.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = NREG_DEF,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = rf_aw(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  input  logic                 flush,
  output logic [NUM_REGS-1:0]  busy,
  output logic                 any_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] set_v;
  logic [NUM_REGS-1:0] clr_v;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (rsv_en && rf_addr_ok(32'(rsv_addr), NUM_REGS, ZERO_REG != 0))
      set_v[rsv_addr] = 1'b1;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && rf_addr_ok(32'(wr_addr[w*AW +: AW]), NUM_REGS, ZERO_REG != 0))
        clr_v[wr_addr[w*AW +: AW]] = 1'b1;
    end
    // A new reservation supersedes the retiring producer; flush overrides both.
    busy_d = flush ? '0 : ((busy_q & ~clr_v) | set_v);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy     = busy_q;
  assign any_busy = |busy_q;

endmodule

// File: rtl/multiport_regfile.sv
// N-read / M-write register file with optional write-to-read bypass and busy scoreboard.
// Reads are zero-latency, writes land at the edge; no backpressure.
module multiport_regfile
  import rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NREG_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = rf_aw(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  input  logic                   flush,
  output logic                   any_busy
);

  logic [XLEN-1:0]     mem      [NUM_REGS];
  logic [XLEN-1:0]     reg_wdat [NUM_REGS];
  logic [NUM_REGS-1:0] reg_hit;
  logic [NUM_REGS-1:0] busy;
  logic [AW-1:0]       wr_a     [NUM_WR];
  logic [XLEN-1:0]     wr_d     [NUM_WR];
  logic [NUM_WR-1:0]   wr_ok;
  logic [AW-1:0]       rd_a     [NUM_RD];
  logic [NUM_RD-1:0]   rd_fwd;

  for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
    assign wr_a[w]  = wr_addr[w*AW +: AW];
    assign wr_d[w]  = wr_data[w*XLEN +: XLEN];
    assign wr_ok[w] = wr_en[w] && rf_addr_ok(32'(wr_a[w]), NUM_REGS, ZERO_REG != 0);
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    assign rd_a[r] = rd_addr[r*AW +: AW];
  end

  // Priority encoder per register: the highest-index matching write port is taken.
  always_comb begin
    reg_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_wdat[i] = '0;
      for (int w = NUM_WR - 1; w >= 0; w--) begin
        if (!reg_hit[i] && wr_ok[w] && (wr_a[w] == AW'(i))) begin
          reg_hit[i]  = 1'b1;
          reg_wdat[i] = wr_d[w];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (reg_hit[i]) mem[i] <= reg_wdat[i];
    end
  end

  // Forwarding is suppressed while in reset so reads stay zero during reset.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_fwd  = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (rf_addr_ok(32'(rd_a[r]), NUM_REGS, ZERO_REG != 0)) begin
        rd_data[r*XLEN +: XLEN] = mem[rd_a[r]];
        rd_busy[r]              = busy[rd_a[r]];
        if ((BYPASS != 0) && rst_n) begin
          for (int w = NUM_WR - 1; w >= 0; w--) begin
            if (!rd_fwd[r] && wr_ok[w] && (wr_a[w] == rd_a[r])) begin
              rd_fwd[r]               = 1'b1;
              rd_data[r*XLEN +: XLEN] = wr_d[w];
              rd_busy[r]              = 1'b0;
            end
          end
        end
      end
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .busy     (busy),
    .any_busy (any_busy)
  );

endmodule

// File: tb/tb_multiport_regfile.sv
// Bench for multiport_regfile: a bypassing 2R/2W instance and a 12-entry non-bypassing 2R/1W instance.
module tb_multiport_regfile;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: 32 regs, 2 read, 2 write, bypass on
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [1:0]  a_wr_en;
  logic [9:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        a_rsv_en;
  logic [4:0]  a_rsv_addr;
  logic        a_flush;
  logic        a_any_busy;

  // Instance B: 12 regs, 2 read, 1 write, bypass off
  logic [7:0]  b_rd_addr;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic [0:0]  b_wr_en;
  logic [3:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic        b_rsv_en;
  logic [3:0]  b_rsv_addr;
  logic        b_flush;
  logic        b_any_busy;

  multiport_regfile #(.NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .rsv_en(a_rsv_en),
    .rsv_addr(a_rsv_addr), .flush(a_flush), .any_busy(a_any_busy)
  );

  multiport_regfile #(.NUM_REGS(12), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .rsv_en(b_rsv_en),
    .rsv_addr(b_rsv_addr), .flush(b_flush), .any_busy(b_any_busy)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  logic [31:0] mdl [32];

  task automatic idle();
    a_rd_addr = '0; a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
    a_rsv_en = 1'b0; a_rsv_addr = '0; a_flush = 1'b0;
    b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
    b_rsv_en = 1'b0; b_rsv_addr = '0; b_flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd5; a_wr_data[31:0] = 32'hDEAD_BEEF;
    a_rd_addr[4:0] = 5'd5; a_rsv_en = 1'b1; a_rsv_addr = 5'd5;
    #2 rst_n = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); total++;
    if (a_rd_data[31:0] !== e) begin bad++; $display("FAIL rst_during_rd got=%h exp=%h", a_rd_data[31:0], e); end
    e = exp_q.pop_front(); total++;
    if (32'(a_any_busy) !== e) begin bad++; $display("FAIL rst_during_any_busy got=%h exp=%h", a_any_busy, e); end
    @(posedge clk); #1;
    idle();
    @(negedge clk) rst_n = 1'b1;
    a_rd_addr[4:0] = 5'd5;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); total++;
    if (a_rd_data[31:0] !== e) begin bad++; $display("FAIL rst_after_rd5 got=%h exp=%h", a_rd_data[31:0], e); end
    e = exp_q.pop_front(); total++;
    if (32'(a_rd_busy[0]) !== e) begin bad++; $display("FAIL rst_after_busy5 got=%h exp=%h", a_rd_busy[0], e); end
    e = exp_q.pop_front(); total++;
    if (32'(a_any_busy) !== e) begin bad++; $display("FAIL rst_after_any_busy got=%h exp=%h", a_any_busy, e); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd3; a_wr_data[31:0] = 32'h1234_5678; a_rd_addr[4:0] = 5'd3;
    b_wr_en = 1'b1;  b_wr_addr = 4'd3;      b_wr_data = 32'h1234_5678;       b_rd_addr[3:0] = 4'd3;
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); total++;
    if (a_rd_data[31:0] !== e) begin bad++; $display("FAIL bypass_same_cycle got=%h exp=%h", a_rd_data[31:0], e); end
    e = exp_q.pop_front(); total++;
    if (b_rd_data[31:0] !== e) begin bad++; $display("FAIL nobypass_same_cycle got=%h exp=%h", b_rd_data[31:0], e); end
    @(posedge clk); #1;
    idle();
    a_rd_addr[4:0] = 5'd3; b_rd_addr[3:0] = 4'd3;
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h1234_5678);
    #1;
    e = exp_q.pop_front(); total++;
    if (a_rd_data[31:0] !== e) begin bad++; $display("FAIL bypass_next_cycle got=%h exp=%h", a_rd_data[31:0], e); end
    e = exp_q.pop_front(); total++;
    if (b_rd_data[31:0] !== e) begin bad++; $display("FAIL nobypass_next_cycle got=%h exp=%h", b_rd_data[31:0], e); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    idle();
    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd0; a_wr_data[31:0] = 32'hFFFF_FFFF;
    a_rsv_en = 1'b1; a_rsv_addr = 5'd0;
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); total++;
    if (a_rd_data[31:0] !== e) begin bad++; $display("FAIL zero_same_cycle got=%h exp=%h", a_rd_data[31:0], e); end
    @(posedge clk); #1;
    idle();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); total++;
    if (a_rd_data[31:0] !== e) begin bad++; $display("FAIL zero_next_cycle got=%h exp=%h", a_rd_data[31:0], e); end
    e = exp_q.pop_front(); total++;
    if (32'(a_any_busy) !== e) begin bad++; $display("FAIL zero_rsv_any_busy got=%h exp=%h", a_any_busy, e); end
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    a_wr_en = 2'b11; a_wr_addr = {5'd7, 5'd7}; a_wr_data = {32'h0000_5555, 32'h0000_AAAA};
    a_rd_addr[4:0] = 5'd7;
    exp_q.push_back(32'h0000_5555);
    #1;
    e = exp_q.pop_front(); total++;
    if (a_rd_data[31:0] !== e) begin bad++; $display("FAIL dual_wr_bypass got=%h exp=%h", a_rd_data[31:0], e); end
    @(posedge clk); #1;
    idle();
    a_rd_addr[4:0] = 5'd7;
    exp_q.push_back(32'h0000_5555);
    #1;
    e = exp_q.pop_front(); total++;
    if (a_rd_data[31:0] !== e) begin bad++; $display("FAIL dual_wr_stored got=%h exp=%h", a_rd_data[31:0], e); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    a_rsv_en = 1'b1; a_rsv_addr = 5'd9; a_rd_addr = {5'd9, 5'd0};
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(a_rd_busy[1]) !== e) begin bad++; $display("FAIL rsv_not_yet_busy got=%h exp=%h", a_rd_busy[1], e); end
    @(posedge clk); #1;
    idle();
    a_rd_addr[9:5] = 5'd9;
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(a_rd_busy[1]) !== e) begin bad++; $display("FAIL rsv_busy9 got=%h exp=%h", a_rd_busy[1], e); end
    e = exp_q.pop_front(); total++;
    if (32'(a_any_busy) !== e) begin bad++; $display("FAIL rsv_any_busy got=%h exp=%h", a_any_busy, e); end
    @(negedge clk);
    a_wr_en = 2'b10; a_wr_addr[9:5] = 5'd9; a_wr_data[63:32] = 32'h0000_0099;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0000_0099);
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(a_rd_busy[1]) !== e) begin bad++; $display("FAIL wb_fwd_busy got=%h exp=%h", a_rd_busy[1], e); end
    e = exp_q.pop_front(); total++;
    if (a_rd_data[63:32] !== e) begin bad++; $display("FAIL wb_fwd_data got=%h exp=%h", a_rd_data[63:32], e); end
    e = exp_q.pop_front(); total++;
    if (32'(a_any_busy) !== e) begin bad++; $display("FAIL wb_any_busy_unbypassed got=%h exp=%h", a_any_busy, e); end
    @(posedge clk); #1;
    idle();
    a_rd_addr[9:5] = 5'd9;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0000_0099);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(a_rd_busy[1]) !== e) begin bad++; $display("FAIL wb_cleared_busy got=%h exp=%h", a_rd_busy[1], e); end
    e = exp_q.pop_front(); total++;
    if (32'(a_any_busy) !== e) begin bad++; $display("FAIL wb_cleared_any got=%h exp=%h", a_any_busy, e); end
    e = exp_q.pop_front(); total++;
    if (a_rd_data[63:32] !== e) begin bad++; $display("FAIL wb_stored_data got=%h exp=%h", a_rd_data[63:32], e); end
  endtask

  task automatic test_collisions();
    @(negedge clk);
    a_rsv_en = 1'b1; a_rsv_addr = 5'd4;
    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd4; a_wr_data[31:0] = 32'h0000_0044;
    @(posedge clk); #1;
    idle();
    a_rd_addr[4:0] = 5'd4;
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0000_0044);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(a_rd_busy[0]) !== e) begin bad++; $display("FAIL rsv_wr_set_wins got=%h exp=%h", a_rd_busy[0], e); end
    e = exp_q.pop_front(); total++;
    if (a_rd_data[31:0] !== e) begin bad++; $display("FAIL rsv_wr_data got=%h exp=%h", a_rd_data[31:0], e); end
    @(negedge clk);
    a_flush = 1'b1; a_rsv_en = 1'b1; a_rsv_addr = 5'd6;
    @(posedge clk); #1;
    idle();
    a_rd_addr = {5'd6, 5'd4};
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); total++;
    if (32'(a_any_busy) !== e) begin bad++; $display("FAIL flush_rsv_any_busy got=%h exp=%h", a_any_busy, e); end
    e = exp_q.pop_front(); total++;
    if (32'(a_rd_busy[0]) !== e) begin bad++; $display("FAIL flush_clears4 got=%h exp=%h", a_rd_busy[0], e); end
    e = exp_q.pop_front(); total++;
    if (32'(a_rd_busy[1]) !== e) begin bad++; $display("FAIL flush_blocks6 got=%h exp=%h", a_rd_busy[1], e); end
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    b_wr_en = 1'b1; b_wr_addr = 4'd13; b_wr_data = 32'h0000_0BAD;
    b_rsv_en = 1'b1; b_rsv_addr = 4'd13; b_rd_addr[3:0] = 4'd13;
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); total++;
    if (b_rd_data[31:0] !== e) begin bad++; $display("FAIL oor_same_cycle got=%h exp=%h", b_rd_data[31:0], e); end
    @(posedge clk); #1;
    idle();
    b_rd_addr[3:0] = 4'd13;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); total++;
    if (b_rd_data[31:0] !== e) begin bad++; $display("FAIL oor_next_cycle got=%h exp=%h", b_rd_data[31:0], e); end
    e = exp_q.pop_front(); total++;
    if (32'(b_any_busy) !== e) begin bad++; $display("FAIL oor_any_busy got=%h exp=%h", b_any_busy, e); end
    @(negedge clk);
    b_wr_en = 1'b1; b_wr_addr = 4'd11; b_wr_data = 32'h0000_CAFE;
    b_rsv_en = 1'b1; b_rsv_addr = 4'd10;
    @(posedge clk); #1;
    idle();
    b_rd_addr = {4'd10, 4'd11};
    exp_q.push_back(32'h0000_CAFE);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); total++;
    if (b_rd_data[31:0] !== e) begin bad++; $display("FAIL top_reg_data got=%h exp=%h", b_rd_data[31:0], e); end
    e = exp_q.pop_front(); total++;
    if (32'(b_rd_busy[1]) !== e) begin bad++; $display("FAIL top_reg_busy got=%h exp=%h", b_rd_busy[1], e); end
    e = exp_q.pop_front(); total++;
    if (32'(b_any_busy) !== e) begin bad++; $display("FAIL top_reg_any_busy got=%h exp=%h", b_any_busy, e); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ra;
    logic [31:0] ex;
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    @(negedge clk) rst_n = 1'b1;
    for (int it = 0; it < 24; it++) begin
      @(negedge clk);
      a_wr_en   = 2'($urandom_range(0, 3));
      a_wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      a_wr_data = {$urandom, $urandom};
      a_rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      for (int r = 0; r < 2; r++) begin
        ra = a_rd_addr[r*5 +: 5];
        ex = (ra == 5'd0) ? 32'h0 : mdl[ra];
        if (ra != 5'd0 && a_wr_en[0] && a_wr_addr[4:0] == ra) ex = a_wr_data[31:0];
        if (ra != 5'd0 && a_wr_en[1] && a_wr_addr[9:5] == ra) ex = a_wr_data[63:32];
        exp_q.push_back(ex);
      end
      #1;
      e = exp_q.pop_front(); total++;
      if (a_rd_data[31:0] !== e) begin bad++; $display("FAIL b2b_rd0 it=%0d got=%h exp=%h", it, a_rd_data[31:0], e); end
      e = exp_q.pop_front(); total++;
      if (a_rd_data[63:32] !== e) begin bad++; $display("FAIL b2b_rd1 it=%0d got=%h exp=%h", it, a_rd_data[63:32], e); end
      @(posedge clk);
      if (a_wr_en[0] && a_wr_addr[4:0] != 5'd0) mdl[a_wr_addr[4:0]] = a_wr_data[31:0];
      if (a_wr_en[1] && a_wr_addr[9:5] != 5'd0) mdl[a_wr_addr[9:5]] = a_wr_data[63:32];
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_dual_write();
    test_scoreboard();
    test_collisions();
    test_out_of_range();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
